lc3_mem_responder: RTL
======================

Name: lc3_mem_responder

Overview:
- Parametrised, cycle-accurate memory responder for the LC3 core's instruction and data ports.
- Replaces the fixed, zero-wait-state memory stub.
- Serves the two channels independently, each with its own programmable wait-state count and one-cycle completion handshake.
- Adds a preload port, saturating fetch counter and sticky stall watchdog. Sits between the core and the bench; instantiated in top in place of direct driver hookup.

Parameters:
ADDR_W, 16, address width of both channels
DATA_W, 16, data word width
DEPTH_LOG2, 16, log2 of memory words; addresses use the low DEPTH_LOG2 bits, upper bits ignored
INSTR_WAIT, 0, extra wait states on instruction channel (0..15)
DATA_WAIT, 0, extra wait states on data channel (0..15)
STALL_THRESH, 1000, consecutive cycles without an instruction completion before stall_err
CNT_W, 32, width of fetch counter

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-high reset
pc  in  ADDR_W  instruction fetch address
instrmem_rd  in  1  instruction fetch request (level)
Instr_dout  out  DATA_W  fetched instruction
complete_instr  out  1  one-cycle fetch completion strobe
data_req  in  1  data access request (level)
Data_rd  in  1  1=read, 0=write; sampled with data_req
Data_addr  in  ADDR_W  data address
Data_din  in  DATA_W  write data from core
Data_dout  out  DATA_W  read data to core
complete_data  out  1  one-cycle data completion strobe
ld_en  in  1  preload write enable
ld_addr  in  ADDR_W  preload address
ld_data  in  DATA_W  preload data
fetch_cnt  out  CNT_W  completed fetches, saturating
stall_err  out  1  sticky watchdog flag

Behaviour:
- Reset is synchronous and active-high: reset is sampled only on the rising edge of clock.
- Reset values: Instr_dout=0, Data_dout=0, complete_instr=0, complete_data=0, fetch_cnt=0, stall_err=0, both FSMs in IDLE, watchdog count=0.
- Memory array contents are not reset; the bench preloads before releasing reset or via ld_en.
- Per-channel FSM: IDLE -> WAIT -> RESP -> IDLE.
  - IDLE: on a request high (instrmem_rd or data_req) with ld_en low, capture address, Data_rd and Data_din. Go to WAIT with counter=wait param; if the param is 0, go straight to RESP.
  - WAIT: decrement each cycle; at 1, go to RESP.
  - RESP: drive data, assert complete for exactly one cycle, return to IDLE.
- Latency: request sampled at edge N gives complete high during cycle N+1+WAIT.
- A request still high in the cycle after RESP starts a new access. Back-to-back throughput is one access per 2+WAIT cycles.
- Address, data and Data_rd changes after capture are ignored until the next IDLE.
- Data write: the array is updated at the RESP edge. Data_dout holds its previous value, and complete_data still pulses.
- Data read: Data_dout is updated at RESP and held until the next data read completes. Instr_dout likewise holds until the next fetch completes.
- Same-address collision:
  - A data write and a fetch completing in the same cycle: the fetch returns the old contents (read-before-write).
  - Data write to an address a later fetch reads: the new value is visible to any fetch whose RESP edge is strictly after the write's.
- Preload priority: while ld_en is high, the array is written at ld_addr every cycle. FSMs in IDLE do not accept requests. FSMs in WAIT or RESP continue unaffected.
- fetch_cnt increments on each complete_instr and saturates at all-ones.
- Watchdog:
  - The counter increments every non-reset cycle without complete_instr and clears on complete_instr.
  - When it reaches STALL_THRESH, stall_err sets and stays high until reset. The counter saturates at STALL_THRESH.
- Reset mid-access: the FSM returns to IDLE next edge and no complete strobe is issued for the aborted access. A pending write is dropped (array unchanged).
- Out-of-range high address bits are ignored, so address 16'hF000 aliases to (16'hF000 mod 2^DEPTH_LOG2).

Test Plan:
1. INSTR_WAIT=0: preload 16'h3000=16'h1261, hold instrmem_rd with pc=16'h3000 from cycle 0 -> complete_instr in cycle 1, Instr_dout=16'h1261, fetch_cnt=1.
2. DATA_WAIT=3: data read at 16'h4000 (preloaded 16'hBEEF) -> complete_data exactly 4 cycles after the request edge, single pulse, Data_dout=16'hBEEF, Instr_dout unchanged.
3. Data write 16'h5A5A to 16'h3002 with a concurrent fetch of 16'h3002 completing the same cycle -> fetch returns the old value; the next fetch returns 16'h5A5A.
4. ld_en held 5 cycles during an instrmem_rd request from IDLE -> no complete_instr until 1 cycle after ld_en falls; preloaded words read back correctly.
5. STALL_THRESH=20, instrmem_rd held low -> stall_err rises after cycle 20 and stays high; a later fetch does not clear it; reset clears it.
6. Reset asserted in WAIT of a DATA_WAIT=5 write -> no complete_data, target word unchanged, all outputs at reset values the next cycle.

Source files
------------

// File: rtl/lc3_mem_responder.sv
// rtl/lc3_mem_responder.sv - LC3 instruction/data memory responder with wait states, preload and stall watchdog
module lc3_mem_responder #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int DEPTH_LOG2   = 16,
    parameter int INSTR_WAIT   = 0,
    parameter int DATA_WAIT    = 0,
    parameter int STALL_THRESH = 1000,
    parameter int CNT_W        = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              instrmem_rd,
    output logic [DATA_W-1:0] Instr_dout,
    output logic              complete_instr,
    input  logic              data_req,
    input  logic              Data_rd,
    input  logic [ADDR_W-1:0] Data_addr,
    input  logic [DATA_W-1:0] Data_din,
    output logic [DATA_W-1:0] Data_dout,
    output logic              complete_data,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [CNT_W-1:0]  fetch_cnt,
    output logic              stall_err
);
    localparam int WD_W = $clog2(STALL_THRESH + 1);
    localparam logic [WD_W-1:0] THRESH = WD_W'(STALL_THRESH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    state_t                i_state, i_state_nx;
    logic [3:0]            i_cnt, i_cnt_nx;
    logic [DEPTH_LOG2-1:0] i_addr, i_addr_nx;

    state_t                d_state, d_state_nx;
    logic [3:0]            d_cnt, d_cnt_nx;
    logic [DEPTH_LOG2-1:0] d_addr, d_addr_nx;
    logic                  d_rd, d_rd_nx;
    logic [DATA_W-1:0]     d_din, d_din_nx;

    logic [WD_W-1:0]       wd_cnt, wd_nx;

    always_comb begin
        i_state_nx = i_state;
        i_cnt_nx   = i_cnt;
        i_addr_nx  = i_addr;
        case (i_state)
            IDLE: if (instrmem_rd && !ld_en) begin
                i_addr_nx  = pc[DEPTH_LOG2-1:0];
                i_cnt_nx   = 4'(INSTR_WAIT);
                i_state_nx = (INSTR_WAIT == 0) ? RESP : WAIT;
            end
            WAIT: if (i_cnt == 4'd1) i_state_nx = RESP;
                  else               i_cnt_nx   = i_cnt - 4'd1;
            default: i_state_nx = IDLE;
        endcase
    end

    always_comb begin
        d_state_nx = d_state;
        d_cnt_nx   = d_cnt;
        d_addr_nx  = d_addr;
        d_rd_nx    = d_rd;
        d_din_nx   = d_din;
        case (d_state)
            IDLE: if (data_req && !ld_en) begin
                d_addr_nx  = Data_addr[DEPTH_LOG2-1:0];
                d_rd_nx    = Data_rd;
                d_din_nx   = Data_din;
                d_cnt_nx   = 4'(DATA_WAIT);
                d_state_nx = (DATA_WAIT == 0) ? RESP : WAIT;
            end
            WAIT: if (d_cnt == 4'd1) d_state_nx = RESP;
                  else               d_cnt_nx   = d_cnt - 4'd1;
            default: d_state_nx = IDLE;
        endcase
    end

    always_comb begin
        wd_nx = wd_cnt;
        if (complete_instr)       wd_nx = '0;
        else if (wd_cnt != THRESH) wd_nx = wd_cnt + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            i_state        <= IDLE;
            i_cnt          <= '0;
            i_addr         <= '0;
            d_state        <= IDLE;
            d_cnt          <= '0;
            d_addr         <= '0;
            d_rd           <= 1'b0;
            d_din          <= '0;
            Instr_dout     <= '0;
            Data_dout      <= '0;
            complete_instr <= 1'b0;
            complete_data  <= 1'b0;
            fetch_cnt      <= '0;
            wd_cnt         <= '0;
            stall_err      <= 1'b0;
        end else begin
            i_state        <= i_state_nx;
            i_cnt          <= i_cnt_nx;
            i_addr         <= i_addr_nx;
            d_state        <= d_state_nx;
            d_cnt          <= d_cnt_nx;
            d_addr         <= d_addr_nx;
            d_rd           <= d_rd_nx;
            d_din          <= d_din_nx;
            complete_instr <= (i_state == RESP);
            complete_data  <= (d_state == RESP);
            // Reads sample the array before this edge's write: read-before-write on collision.
            if (i_state == RESP) Instr_dout <= mem[i_addr];
            if (d_state == RESP && d_rd) Data_dout <= mem[d_addr];
            if (i_state == RESP && fetch_cnt != '1) fetch_cnt <= fetch_cnt + 1'b1;
            wd_cnt         <= wd_nx;
            stall_err      <= stall_err | (wd_nx == THRESH);
        end
    end

    // Preload is applied last so it wins a same-address collision; it also works while in reset.
    always_ff @(posedge clock) begin
        if (!reset && d_state == RESP && !d_rd) mem[d_addr] <= d_din;
        if (ld_en) mem[ld_addr[DEPTH_LOG2-1:0]] <= ld_data;
    end
endmodule
